// File: rtl/mul_req_master.sv
// mul_req_master: feeds operand pairs to the sequential multiplier (seq_mul).
//   Operand pairs arrive on a valid/ready port and are buffered in a FIFO.
//   The FSM pops one pair at a time and drives it out on req/req_data.
//   It waits for ack/ack_data, then returns the product as a one-cycle res_valid pulse.
//   Completed operations are counted in done_cnt.
//   err is set sticky on an ack timeout or on an ack that arrives while no request is pending.
// Ports:
//   clk, rst                 clock (posedge) and async active-high reset
//   in_valid/in_ready/in_op* operand source handshake
//   req/req_data/ack/ack_data  request/ack link to seq_mul
//   res_valid/res_data       product pulse and held product
//   done_cnt, err            completion counter and sticky fault flag
module mul_req_master #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int TMO   = 64,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_op1,
  input  logic [DW-1:0]   in_op2,
  output logic            req,
  output logic [2*DW-1:0] req_data,
  input  logic            ack,
  input  logic [2*DW-1:0] ack_data,
  output logic            res_valid,
  output logic [2*DW-1:0] res_data,
  output logic [CW-1:0]   done_cnt,
  output logic            err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef struct packed {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } pair_t;

  typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

  // FIFO: pointers carry one extra wrap bit so full and empty can be told apart
  pair_t       mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  pair_t       head;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;          // no pass-through: a same-cycle pop does not free a slot
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op1: in_op1, op2: in_op2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM and registered outputs
  state_t          state, state_d;
  logic [TW-1:0]   tmo, tmo_d;
  logic            tmo_hit;
  logic            req_d, res_valid_d, err_d;
  logic [2*DW-1:0] req_data_d, res_data_d;
  logic [CW-1:0]   done_d;

  assign tmo_hit = (tmo == TW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo       <= '0;
      req       <= 1'b0;
      req_data  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      done_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      tmo       <= tmo_d;
      req       <= req_d;
      req_data  <= req_data_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      done_cnt  <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        // an ack with nothing outstanding is a fault and takes priority over issuing
        if (ack)         state_d = ERR;
        else if (!empty) state_d = REQ;
      end
      REQ: begin
        if (ack) begin
          if (empty) state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = ERR;
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    tmo_d       = tmo;
    req_d       = req;
    req_data_d  = req_data;
    res_valid_d = 1'b0;
    res_data_d  = res_data;
    done_d      = done_cnt;
    err_d       = err;
    case (state)
      IDLE: begin
        if (ack) begin
          err_d = 1'b1;
        end else if (!empty) begin
          pop        = 1'b1;
          req_d      = 1'b1;
          req_data_d = head;
          tmo_d      = '0;
        end
      end
      REQ: begin
        if (ack) begin
          res_valid_d = 1'b1;
          res_data_d  = ack_data;
          done_d      = done_cnt + 1'b1;
          if (!empty) begin
            // back-to-back: req stays high and the next operand replaces the acked one
            pop        = 1'b1;
            req_data_d = head;
            tmo_d      = '0;
          end else begin
            req_d      = 1'b0;
            req_data_d = '0;
          end
        end else if (tmo_hit) begin
          // the in-flight operand is dropped
          err_d      = 1'b1;
          req_d      = 1'b0;
          req_data_d = '0;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      default: begin
        req_d      = 1'b0;
        req_data_d = '0;
      end
    endcase
  end

endmodule
